// File: rtl/kf_pkg.sv
// Shared types and default widths for the Kalman filter host-side blocks.
package kf_pkg;

   localparam int KF_W      = 24;   // core datapath word width
   localparam int KF_ADDRW  = 5;    // data bank address width
   localparam int KF_ROM_AW = 8;    // sequencer ROM address width
   localparam int KF_ROM_DW = 16;   // sequencer instruction width

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      START   = 3'd2,
      WAIT_LO = 3'd3,
      WAIT_HI = 3'd4,
      OUT     = 3'd5
   } kf_state_t;

   // Width of a counter that must be able to hold the value nin.
   function automatic int kf_cnt_width(input int nin);
      return $clog2(nin + 1);
   endfunction

endpackage

// File: rtl/kf_host_ctrl_if.sv
// Bundle of the host controller's stream, bus and core-side signals.
// master: the host controller itself. slave: the fabric plus filter core around it.
interface kf_host_ctrl_if
   import kf_pkg::*;
#(
   parameter int W     = KF_W,
   parameter int ADDRW = KF_ADDRW
) ();

   // ROM program download stream
   logic                 prog_valid;
   logic                 prog_ready;
   logic [KF_ROM_AW-1:0] prog_addr;
   logic [KF_ROM_DW-1:0] prog_data;

   // input word stream
   logic                 in_valid;
   logic                 in_ready;
   logic [W-1:0]         in_data;

   // result stream and status
   logic                 res_valid;
   logic                 res_ready;
   logic [W-1:0]         res_data;
   logic                 err_timeout;
   logic                 busy;

   // filter core external interface
   logic                 kf_rom_we;
   logic [KF_ROM_AW-1:0] kf_rom_waddr;
   logic [KF_ROM_DW-1:0] kf_rom_wdata;
   logic [W-1:0]         kf_data_in;
   logic [ADDRW-1:0]     kf_dir;
   logic                 kf_write;
   logic                 kf_start;
   logic                 kf_ready;
   logic [W-1:0]         kf_data_out;

   modport master (
      input  prog_valid, prog_addr, prog_data,
      input  in_valid, in_data,
      input  res_ready,
      input  kf_ready, kf_data_out,
      output prog_ready, in_ready,
      output res_valid, res_data, err_timeout, busy,
      output kf_rom_we, kf_rom_waddr, kf_rom_wdata,
      output kf_data_in, kf_dir, kf_write, kf_start
   );

   modport slave (
      output prog_valid, prog_addr, prog_data,
      output in_valid, in_data,
      output res_ready,
      output kf_ready, kf_data_out,
      input  prog_ready, in_ready,
      input  res_valid, res_data, err_timeout, busy,
      input  kf_rom_we, kf_rom_waddr, kf_rom_wdata,
      input  kf_data_in, kf_dir, kf_write, kf_start
   );

endinterface

// File: rtl/kf_host_timer.sv
// Saturating cycle counter with clear and enable.
// o_hit marks the enabled tick on which the count reaches TIMEOUT;
// o_term is high while the count is parked at TIMEOUT.
module kf_host_timer #(
   parameter int TIMEOUT = 1023,
   parameter int CW      = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_hit,
   output logic o_term
);

   logic [CW-1:0] r_count;

   assign o_term = (r_count == CW'(TIMEOUT));
   assign o_hit  = i_en && !i_clr && (r_count == CW'(TIMEOUT - 1));

   // Count enabled cycles, clear has priority, stop at TIMEOUT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_count <= '0;
      else if (i_clr)
         r_count <= '0;
      else if (i_en && !o_term)
         r_count <= r_count + 1'b1;
   end

endmodule

// File: rtl/kf_host_ctrl.sv
// Host-side initiator for one Kalman filter core: optional ROM download,
// NIN data-bank writes, START/READY handshake with timeout, result stream.
module kf_host_ctrl
   import kf_pkg::*;
#(
   parameter int W       = KF_W,
   parameter int ADDRW   = KF_ADDRW,
   parameter int NIN     = 4,
   parameter int BASE    = 0,
   parameter int TIMEOUT = 1023
) (
   input  logic           clk,
   input  logic           rst_n,
   kf_host_ctrl_if.master bus
);

   localparam int               CW       = kf_cnt_width(NIN);
   localparam logic [ADDRW-1:0] BASE_MOD = ADDRW'(BASE % (2 ** ADDRW));

   kf_state_t        r_state;
   kf_state_t        w_state_next;
   logic [CW-1:0]    r_cnt;

   logic             w_prog_ready;
   logic             w_in_ready;
   logic             w_prog_acc;
   logic             w_in_acc;
   logic             w_last_word;
   logic [ADDRW-1:0] w_dir;
   logic             w_tmr_clr;
   logic             w_tmr_en;
   logic             w_tmr_hit;
   logic             w_tmr_term;
   logic             w_timeout;

   logic             r_rom_we;
   logic [KF_ROM_AW-1:0] r_rom_waddr;
   logic [KF_ROM_DW-1:0] r_rom_wdata;
   logic             r_kf_write;
   logic [W-1:0]     r_kf_data_in;
   logic [ADDRW-1:0] r_kf_dir;
   logic             r_kf_start;
   logic             r_res_valid;
   logic [W-1:0]     r_res_data;
   logic             r_err;

   // Ready outputs are held low while reset is asserted so every output reads 0.
   assign bus.prog_ready = w_prog_ready & rst_n;
   assign bus.in_ready   = w_in_ready & rst_n;
   assign w_prog_acc     = bus.prog_valid & bus.prog_ready;
   assign w_in_acc       = bus.in_valid & bus.in_ready;
   assign w_last_word    = (r_cnt == CW'(NIN - 1));
   assign w_dir          = BASE_MOD + ADDRW'(r_cnt);
   assign w_timeout      = w_tmr_hit | (w_tmr_en & w_tmr_term);

   assign bus.busy         = (r_state != IDLE);
   assign bus.kf_rom_we    = r_rom_we;
   assign bus.kf_rom_waddr = r_rom_waddr;
   assign bus.kf_rom_wdata = r_rom_wdata;
   assign bus.kf_write     = r_kf_write;
   assign bus.kf_data_in   = r_kf_data_in;
   assign bus.kf_dir       = r_kf_dir;
   assign bus.kf_start     = r_kf_start;
   assign bus.res_valid    = r_res_valid;
   assign bus.res_data     = r_res_data;
   assign bus.err_timeout  = r_err;

   kf_host_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_tmr_clr),
      .i_en   (w_tmr_en),
      .o_hit  (w_tmr_hit),
      .o_term (w_tmr_term)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_in_acc) w_state_next = w_last_word ? START : LOAD;
         LOAD:    if (w_in_acc && w_last_word) w_state_next = START;
         START:   if (bus.kf_ready) w_state_next = WAIT_LO;
         WAIT_LO: begin
            if (w_timeout)          w_state_next = IDLE;
            else if (!bus.kf_ready) w_state_next = WAIT_HI;
         end
         // A READY rise on the terminal cycle still delivers the result.
         WAIT_HI: begin
            if (bus.kf_ready)       w_state_next = OUT;
            else if (w_timeout)     w_state_next = IDLE;
         end
         OUT:     if (bus.res_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Per-state handshake readiness and timer control
   always_comb begin
      w_prog_ready = 1'b0;
      w_in_ready   = 1'b0;
      w_tmr_clr    = 1'b0;
      w_tmr_en     = 1'b0;
      case (r_state)
         IDLE: begin
            w_prog_ready = 1'b1;
            w_in_ready   = !bus.prog_valid;   // ROM words win over data
         end
         LOAD:             w_in_ready = 1'b1;
         START:            w_tmr_clr  = 1'b1;
         WAIT_LO, WAIT_HI: w_tmr_en   = 1'b1;
         default: ;
      endcase
   end

   // Word counter: restarts whenever the FSM heads back to IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (w_state_next == IDLE)
         r_cnt <= '0;
      else if (w_in_acc)
         r_cnt <= r_cnt + 1'b1;
   end

   // Registered core-side outputs, result capture and timeout pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rom_we     <= 1'b0;
         r_rom_waddr  <= '0;
         r_rom_wdata  <= '0;
         r_kf_write   <= 1'b0;
         r_kf_data_in <= '0;
         r_kf_dir     <= '0;
         r_kf_start   <= 1'b0;
         r_res_valid  <= 1'b0;
         r_res_data   <= '0;
         r_err        <= 1'b0;
      end else begin
         r_rom_we <= w_prog_acc;
         if (w_prog_acc) begin
            r_rom_waddr <= bus.prog_addr;
            r_rom_wdata <= bus.prog_data;
         end
         r_kf_write <= w_in_acc;
         if (w_in_acc) begin
            r_kf_data_in <= bus.in_data;
            r_kf_dir     <= w_dir;
         end
         r_kf_start <= (r_state == START) && bus.kf_ready;
         r_err      <= ((r_state == WAIT_LO) && w_timeout) ||
                       ((r_state == WAIT_HI) && w_timeout && !bus.kf_ready);
         if ((r_state == WAIT_HI) && bus.kf_ready) begin
            r_res_valid <= 1'b1;
            r_res_data  <= bus.kf_data_out;
         end else if ((r_state == OUT) && bus.res_ready) begin
            r_res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_kf_host_ctrl.sv
// Scoreboard bench: two controllers (BASE 8 and BASE 30) share one stimulus
// stream and one core model; expected events are queued, monitors pop them.
module tb_kf_host_ctrl;
   import kf_pkg::*;

   localparam int BASE_A = 8;
   localparam int BASE_B = 30;
   localparam int TMO    = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pv, iv, rr, kr;
   logic [7:0]  pa;
   logic [15:0] pd;
   logic [23:0] id, kdo;

   int          lo_cycles = 20;
   logic [23:0] core_val = '0;
   bit          stuck = 1'b0;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int res_cnt  = 0;

   typedef struct {
      int          cyc;
      logic [31:0] a;
      logic [31:0] d;
   } ev_t;

   ev_t q_rom[$];
   ev_t q_wr_a[$];
   ev_t q_wr_b[$];
   ev_t q_res[$];
   int  q_start[$];
   int  q_err[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   kf_host_ctrl_if #(.W(24), .ADDRW(5)) ifa ();
   kf_host_ctrl_if #(.W(24), .ADDRW(5)) ifb ();

   assign ifa.prog_valid  = pv;  assign ifb.prog_valid  = pv;
   assign ifa.prog_addr   = pa;  assign ifb.prog_addr   = pa;
   assign ifa.prog_data   = pd;  assign ifb.prog_data   = pd;
   assign ifa.in_valid    = iv;  assign ifb.in_valid    = iv;
   assign ifa.in_data     = id;  assign ifb.in_data     = id;
   assign ifa.res_ready   = rr;  assign ifb.res_ready   = rr;
   assign ifa.kf_ready    = kr;  assign ifb.kf_ready    = kr;
   assign ifa.kf_data_out = kdo; assign ifb.kf_data_out = kdo;

   kf_host_ctrl #(.W(24), .ADDRW(5), .NIN(4), .BASE(BASE_A), .TIMEOUT(TMO)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa)
   );

   kf_host_ctrl #(.W(24), .ADDRW(5), .NIN(4), .BASE(BASE_B), .TIMEOUT(TMO)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_unexp(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: event seen at cycle %0d, expected none", name, cyc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Core model: on START, drop READY, hold it low lo_cycles, then present DATA_OUT.
   initial begin
      kr  = 1'b1;
      kdo = '0;
      forever begin
         @(negedge clk);
         if (ifa.kf_start && !stuck) begin
            kr = 1'b0;
            repeat (lo_cycles) @(negedge clk);
            kdo = core_val;
            kr  = 1'b1;
         end
      end
   end

   // Monitor: pops expectations whenever a DUT presents an event
   always @(negedge clk) begin
      ev_t e;
      int  c;
      if (ifa.kf_rom_we) begin
         if (q_rom.size() == 0) fail_unexp("rom_we");
         else begin
            e = q_rom.pop_front();
            chk("rom cycle", 32'(cyc), 32'(e.cyc));
            chk("rom addr", 32'(ifa.kf_rom_waddr), e.a);
            chk("rom data", 32'(ifa.kf_rom_wdata), e.d);
            $display("rom   cyc=%0d addr=%02h data=%04h", cyc, ifa.kf_rom_waddr, ifa.kf_rom_wdata);
         end
      end
      if (ifa.kf_write) begin
         if (q_wr_a.size() == 0) fail_unexp("write a");
         else begin
            e = q_wr_a.pop_front();
            chk("write a cycle", 32'(cyc), 32'(e.cyc));
            chk("write a dir", 32'(ifa.kf_dir), e.a);
            chk("write a data", 32'(ifa.kf_data_in), e.d);
            $display("wr_a  cyc=%0d dir=%0d data=%06h", cyc, ifa.kf_dir, ifa.kf_data_in);
         end
      end
      if (ifb.kf_write) begin
         if (q_wr_b.size() == 0) fail_unexp("write b");
         else begin
            e = q_wr_b.pop_front();
            chk("write b cycle", 32'(cyc), 32'(e.cyc));
            chk("write b dir", 32'(ifb.kf_dir), e.a);
            chk("write b data", 32'(ifb.kf_data_in), e.d);
            $display("wr_b  cyc=%0d dir=%0d data=%06h", cyc, ifb.kf_dir, ifb.kf_data_in);
         end
      end
      if (ifa.kf_start) begin
         if (q_start.size() == 0) fail_unexp("kf_start");
         else begin
            c = q_start.pop_front();
            chk("start cycle", 32'(cyc), 32'(c));
            $display("start cyc=%0d", cyc);
         end
      end
      if (ifa.err_timeout) begin
         if (q_err.size() == 0) fail_unexp("err_timeout");
         else begin
            c = q_err.pop_front();
            chk("timeout cycle", 32'(cyc), 32'(c));
            $display("tmo   cyc=%0d", cyc);
         end
      end
      if (!rst_n) res_cnt = 0;
      else if (ifa.res_valid) begin
         if (q_res.size() == 0) fail_unexp("res_valid");
         else begin
            res_cnt++;
            chk("res_data", 32'(ifa.res_data), q_res[0].a);
            if (rr) begin
               chk("res valid cycles", 32'(res_cnt), q_res[0].d);
               $display("res   cyc=%0d data=%06h after %0d cycles", cyc, ifa.res_data, res_cnt);
               e = q_res.pop_front();
               res_cnt = 0;
            end
         end
      end
   end

   task automatic check_outputs(input bit rdy);
      chk("prog_ready", 32'(ifa.prog_ready), 32'(rdy));
      chk("in_ready", 32'(ifa.in_ready), 32'(rdy));
      chk("res_valid", 32'(ifa.res_valid), 0);
      chk("res_data", 32'(ifa.res_data), 0);
      chk("err_timeout", 32'(ifa.err_timeout), 0);
      chk("busy", 32'(ifa.busy), 0);
      chk("kf_rom_we", 32'(ifa.kf_rom_we), 0);
      chk("kf_rom_waddr", 32'(ifa.kf_rom_waddr), 0);
      chk("kf_rom_wdata", 32'(ifa.kf_rom_wdata), 0);
      chk("kf_data_in", 32'(ifa.kf_data_in), 0);
      chk("kf_dir", 32'(ifa.kf_dir), 0);
      chk("kf_write", 32'(ifa.kf_write), 0);
      chk("kf_start", 32'(ifa.kf_start), 0);
   endtask

   // All stimulus tasks start and end one time unit after a rising edge.
   task automatic send_prog(input logic [7:0] a, input logic [15:0] d, output int acc);
      int n = 0;
      pv = 1'b1; pa = a; pd = d;
      #1;
      while (!ifa.prog_ready && n < 100) begin step(); #1; n++; end
      acc = -1;
      if (!ifa.prog_ready) fail_unexp("prog_ready wait expired");
      else begin
         acc = cyc;
         q_rom.push_back(ev_t'{acc + 1, 32'(a), 32'(d)});
      end
      step();
      pv = 1'b0;
   endtask

   task automatic send_word(input logic [23:0] d, input int k, output int acc);
      int n = 0;
      iv = 1'b1; id = d;
      #1;
      while (!ifa.in_ready && n < 100) begin step(); #1; n++; end
      acc = -1;
      if (!ifa.in_ready) fail_unexp("in_ready wait expired");
      else begin
         acc = cyc;
         q_wr_a.push_back(ev_t'{acc + 1, 32'(BASE_A + k), 32'(d)});
         q_wr_b.push_back(ev_t'{acc + 1, 32'((BASE_B + k) % 32), 32'(d)});
      end
      step();
      iv = 1'b0;
   endtask

   task automatic load_words(input logic [23:0] w0, input logic [23:0] w1,
                             input logic [23:0] w2, input logic [23:0] w3,
                             input bit gap, output int last);
      int a;
      send_word(w0, 0, a);
      send_word(w1, 1, a);
      if (gap) step();
      send_word(w2, 2, a);
      send_word(w3, 3, last);
      q_start.push_back(last + 2);
   endtask

   task automatic consume(input int hold);
      int n = 0;
      while (!ifa.res_valid && n < 300) begin step(); n++; end
      if (!ifa.res_valid) fail_unexp("res_valid wait expired");
      repeat (hold) step();
      rr = 1'b1;
      step();
      rr = 1'b0;
      chk("res_valid after handshake", 32'(ifa.res_valid), 0);
      chk("busy after handshake", 32'(ifa.busy), 0);
   endtask

   task automatic run_iter(input logic [23:0] w0, input logic [23:0] w1,
                           input logic [23:0] w2, input logic [23:0] w3,
                           input bit gap, input int lo, input logic [23:0] val,
                           input int hold);
      int last;
      lo_cycles = lo;
      core_val  = val;
      load_words(w0, w1, w2, w3, gap, last);
      q_res.push_back(ev_t'{0, 32'(val), 32'(hold + 1)});
      consume(hold);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2, a3, last, n;
      pv = 1'b0; iv = 1'b0; rr = 1'b0; pa = '0; pd = '0; id = '0;

      // Reset state
      #3;
      check_outputs(1'b0);
      step(); step();
      rst_n = 1'b1;
      #1;
      check_outputs(1'b1);
      step();

      // Back-to-back ROM download
      send_prog(8'h10, 16'hA5C3, a1);
      send_prog(8'h11, 16'h0001, a2);
      send_prog(8'h12, 16'hFFFF, a3);
      chk("prog back-to-back 2", 32'(a2), 32'(a1 + 1));
      chk("prog back-to-back 3", 32'(a3), 32'(a2 + 1));
      step(); step();

      // Normal iteration, slow READY, consumer stalls 5 cycles
      run_iter(24'h004000, 24'h002000, 24'h001000, 24'h000800, 1'b0, 20, 24'h00C000, 5);

      // Core never acknowledges START: timeout after TMO cycles
      stuck = 1'b1;
      load_words(24'h000100, 24'h000200, 24'h000300, 24'h000400, 1'b0, last);
      q_err.push_back(last + 2 + TMO);
      n = 0;
      step();
      while (ifa.busy && n < 300) begin step(); n++; end
      chk("busy after timeout", 32'(ifa.busy), 0);
      stuck = 1'b0;
      step();

      // Recovery iteration with a gap in the input stream
      run_iter(24'h111111, 24'h222222, 24'h333333, 24'h444444, 1'b1, 3, 24'h123456, 0);
      step();

      // ROM word has priority over a simultaneous data word
      pv = 1'b1; pa = 8'h20; pd = 16'h5A5A; iv = 1'b1; id = 24'h000011;
      #1;
      chk("in_ready with prog_valid", 32'(ifa.in_ready), 0);
      chk("prog_ready with in_valid", 32'(ifa.prog_ready), 1);
      q_rom.push_back(ev_t'{cyc + 1, 32'h20, 32'h5A5A});
      step();
      pv = 1'b0;
      lo_cycles = 20;
      core_val  = 24'hABCDEF;
      load_words(24'h000011, 24'h000022, 24'h000033, 24'h000044, 1'b0, last);
      repeat (8) step();
      chk("busy in WAIT_HI", 32'(ifa.busy), 1);

      // Asynchronous reset mid-iteration
      rst_n = 1'b0;
      #1;
      check_outputs(1'b0);
      repeat (25) step();
      rst_n = 1'b1;
      #1;
      check_outputs(1'b1);
      step();

      // Fresh iteration after reset
      run_iter(24'h000001, 24'h000002, 24'h000003, 24'h000004, 1'b0, 2, 24'h000777, 2);
      repeat (3) step();

      chk("rom queue drained", 32'(q_rom.size()), 0);
      chk("write a queue drained", 32'(q_wr_a.size()), 0);
      chk("write b queue drained", 32'(q_wr_b.size()), 0);
      chk("start queue drained", 32'(q_start.size()), 0);
      chk("timeout queue drained", 32'(q_err.size()), 0);
      chk("result queue drained", 32'(q_res.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
